// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with a valid/ready handshake, flush-to-bubble,
// an optional 2-entry skid buffer and saturating stall/bubble counters.
module pipe_stage_buf #(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit                SKID        = 1'b1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t m_q, s_q, in_ent;
  logic   m_vld, s_vld;
  logic   xfer_in, xfer_out;

  assign in_ent   = '{ctrl: in_ctrl, data: in_data};
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = m_vld && out_ready;

  // With the skid entry, in_ready depends only on state, breaking the
  // combinational ready chain through the pipeline.
  generate
    if (SKID) begin : g_skid
      assign in_ready = !s_vld;
    end else begin : g_noskid
      assign in_ready = !m_vld || out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else if (flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (xfer_out) begin
      if (s_vld) begin
        m_q   <= s_q;
        s_vld <= 1'b0;
      end else if (xfer_in) begin
        m_q <= in_ent;
      end else begin
        m_vld <= 1'b0;
      end
    end else if (xfer_in) begin
      if (!m_vld) begin
        m_q   <= in_ent;
        m_vld <= 1'b1;
      end else if (SKID) begin
        s_q   <= in_ent;
        s_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (m_vld && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (!m_vld && bubble_cnt != '1)             bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign out_valid = m_vld;
  assign out_data  = m_q.data;
  assign out_ctrl  = m_vld ? m_q.ctrl : BUBBLE_CTRL;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives a skid and a no-skid stage with shared stimulus and compares both
// against a FIFO-occupancy reference model every cycle.
module tb_pipe_stage_buf;
  localparam logic [7:0] BUB = 8'hA5;
  localparam int         SAT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic [1:0]        ov, ir;
  logic [1:0][31:0]  od;
  logic [1:0][7:0]   oc;
  logic [1:0][3:0]   sc, bc;

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .BUBBLE_CTRL(BUB), .SKID(1'b1), .CNT_W(4)) u_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ctrl(oc[0]), .stall_cnt(sc[0]), .bubble_cnt(bc[0]));

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .BUBBLE_CTRL(BUB), .SKID(1'b0), .CNT_W(4)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ctrl(oc[1]), .stall_cnt(sc[1]), .bubble_cnt(bc[1]));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference: per DUT an ordered list of held beats (capacity 2 or 1).
  logic [31:0] md[2][2];
  logic [7:0]  mc[2][2];
  int          mcnt[2];
  logic [31:0] mlast[2];
  int          mstall[2], mbub[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_rdy(input int k, input logic ordy);
    if (k == 0) return mcnt[k] < 2;
    return mcnt[k] == 0 || ordy;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mlast[k] = '0; mstall[k] = 0; mbub[k] = 0;
    end
  endtask

  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] d, input logic [7:0] c, input logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      string p;
      bit    v, rdy;
      p   = (k == 0) ? "skid" : "noskid";
      v   = mcnt[k] > 0;
      rdy = model_rdy(k, ordy);
      if (chk_en) begin
        chk({p, ".out_valid"}, 64'(ov[k]), 64'(v));
        chk({p, ".in_ready"},  64'(ir[k]), 64'(rdy));
        chk({p, ".out_data"},  64'(od[k]), 64'(v ? md[k][0] : mlast[k]));
        chk({p, ".out_ctrl"},  64'(oc[k]), 64'(v ? mc[k][0] : BUB));
        chk({p, ".stall_cnt"}, 64'(sc[k]), 64'(mstall[k]));
        chk({p, ".bubble_cnt"},64'(bc[k]), 64'(mbub[k]));
      end
      if (rst) begin
        mcnt[k] = 0; mlast[k] = '0; mstall[k] = 0; mbub[k] = 0;
      end else begin
        if (v && !ordy && mstall[k] < SAT) mstall[k]++;
        if (!v && mbub[k] < SAT)           mbub[k]++;
        if (fl) mcnt[k] = 0;
        else begin
          if (v && ordy) begin
            md[k][0] = md[k][1]; mc[k][0] = mc[k][1]; mcnt[k]--;
          end
          if (iv && rdy) begin
            md[k][mcnt[k]] = d; mc[k][mcnt[k]] = c; mcnt[k]++;
          end
        end
        if (mcnt[k] > 0) mlast[k] = md[k][0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    step(1, 0, 0, 0, 0, 1);

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 32'(i), 8'(i), 1);
    chk("stream.last_data", 64'(od[0]), 64'h8);
    step(0, 0, 0, 0, 0, 1);

    // Stall fills M and S on the skid stage.
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h11, 8'h01, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h12 + 32'(i), 8'h02, 0);
    chk("stall.stall_cnt", 64'(sc[0]), 64'd3);
    chk("stall.in_ready",  64'(ir[0]), 64'd0);
    chk("stall.head",      64'(od[0]), 64'h11);

    // Flush with both entries full and a beat offered.
    step(0, 1, 1, 32'h99, 8'h09, 0);
    chk("flush.out_valid", 64'(ov[0]), 64'd0);
    chk("flush.out_ctrl",  64'(oc[0]), 64'(BUB));
    chk("flush.in_ready",  64'(ir[0]), 64'd1);
    step(0, 0, 0, 0, 0, 1);

    // Toggling out_ready: no-skid in_ready follows occupancy/out_ready.
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 32'h100 + 32'(i), 8'(i), 1'(~i[0]));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

    // Idle saturation of bubble counter.
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 1);
    chk("idle.bubble_sat",   64'(bc[0]), 64'd15);
    chk("idle.bubble_sat_n", 64'(bc[1]), 64'd15);

    // Reset mid-stream with both entries full.
    step(0, 0, 1, 32'hA1, 8'h1, 0);
    step(0, 0, 1, 32'hA2, 8'h2, 0);
    step(1, 0, 1, 32'hA3, 8'h3, 0);
    chk("rst.out_valid", 64'(ov[0]), 64'd0);
    chk("rst.out_data",  64'(od[0]), 64'd0);
    chk("rst.stall_cnt", 64'(sc[0]), 64'd0);
    chk("rst.bubble_cnt",64'(bc[0]), 64'd0);
    chk("rst.in_ready",  64'(ir[0]), 64'd1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      logic r, f, v, o;
      r = ($urandom_range(0, 79) == 0);
      f = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      step(r, f, v, $urandom, 8'($urandom_range(0, 255)), o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
